nrzi_serial_tx: RTL and testbench
=================================

Name: nrzi_serial_tx

Overview:
Parallel-in, serial-out transition-encoding (NRZI) transmitter. It drives the single-bit line `x` so that a downstream transition detector recovers the data: a data bit of 1 produces a level change on `x`, and a data bit of 0 holds the level. It accepts one WIDTH-bit word per valid/ready handshake, shifts it out one bit per clock, then pulses `done`.

Parameters:
- WIDTH, 8, number of data bits per word (≥2).
- LSB_FIRST, 1, 1: bit 0 is sent first; 0: bit WIDTH-1 is sent first.
- IDLE_LEVEL, 0, level of `x` after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- data_in  input  WIDTH  word to transmit; sampled only at acceptance.
- load  input  1  word-valid request.
- ready  output  1  high when a new word can be accepted.
- busy  output  1  high while a word is in flight.
- done  output  1  one-cycle pulse when a word completes.
- x  output  1  NRZI-encoded serial line; registered.

Behaviour:
- Reset (rst=1 at an edge): after that edge, x=IDLE_LEVEL, ready=1, busy=0, done=0, shift register=0, bit counter=0, state=IDLE. rst has priority over every other input.
- States:
  - IDLE: ready=1.
  - SEND: ready=0, busy=1.
  - DONE: ready=0, busy=1.
- Acceptance:
  - At edge T, if state=IDLE and load=1, the word is accepted.
  - At T: shift register <= data_in, counter <= 0, ready <= 0, busy <= 1, state <= SEND.
  - data_in is don't-care after T.
- Encoding in SEND:
  - At each edge T+k (k = 1..WIDTH), the current bit b is the LSB of the shift register if LSB_FIRST=1, else the MSB.
  - x <= x ^ b; the shift register shifts toward the consumed end; counter increments.
  - The last bit appears on x after edge T+WIDTH; at that edge, state <= DONE.
- Latency:
  - First bit is on x one cycle after acceptance.
  - Bit i is on x after edge T+1+i.
- DONE:
  - At edge T+WIDTH+1: done <= 1, ready <= 1, busy <= 0, state <= IDLE.
  - At the following edge: done <= 0, unless rst.
  - done is high for exactly one cycle per completed word.
- Line level:
  - x holds its value whenever not encoding a 1, including in IDLE and DONE.
  - x never returns to IDLE_LEVEL between words; only rst forces IDLE_LEVEL.
  - The final level of a word carries into the next.
- Back-to-back words: with load held high, the next acceptance occurs at edge T+WIDTH+2. The minimum period is WIDTH+2 cycles per word; x holds level during the 2 gap cycles.
- load while busy=1: ignored; no queuing, no effect on the current word.
- Reset mid-word: the word is discarded, x=IDLE_LEVEL, no done pulse, ready=1 after the reset edge.
- Reset in the same cycle as load: reset wins and the word is not accepted.
- Counter width: $clog2(WIDTH+1).
- No combinational path from any input to any output.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with load=1 and data_in=8'hFF -> x=0, ready=1, busy=0, done=0; no word accepted after rst drops until load is sampled with ready=1.
2. LSB_FIRST=1, x=0, accept 8'b1011_0010 at edge T -> x after edges T+1..T+8 = 0,1,1,1,0,1,1,0. done=1 only for the cycle after T+9; ready=1 and busy=0 after T+9.
3. Accept 8'hFF from x=0 -> x = 1,0,1,0,1,0,1,0. Then 8'h00 -> x stays constant for 8 cycles. With LSB_FIRST=0, 8'h80 -> x = 1,1,1,1,1,1,1,1.
4. During SEND of 8'h0F, pulse load with data_in=8'hAA at T+3 -> ignored. x follows 8'h0F only, and exactly one done pulse occurs.
5. Assert rst at edge T+4 of a word -> after that edge x=IDLE_LEVEL, ready=1, busy=0; done never pulses for that word.
6. load held high with 8'hFF accepted at T (x=0), then 8'h01 -> second acceptance at T+10; x=0 after T+8..T+10, x=1 after T+11 and remains 1 through T+18; done pulses after T+9 and after T+19.

Source files
------------

// File: rtl/nrzi_serial_tx.sv
// rtl/nrzi_serial_tx.sv - parallel-in, NRZI-encoded serial-out transmitter
module nrzi_serial_tx #(
    parameter int WIDTH      = 8,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             x
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    bit_cnt;
    logic             cur_bit;
    logic [WIDTH-1:0] shift_next;

    assign cur_bit    = LSB_FIRST ? shift_reg[0] : shift_reg[WIDTH-1];
    assign shift_next = LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            x         <= IDLE_LEVEL;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load) begin
                        shift_reg <= data_in;
                        bit_cnt   <= '0;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    // A 1 toggles the line, a 0 holds it.
                    x         <= x ^ cur_bit;
                    shift_reg <= shift_next;
                    bit_cnt   <= bit_cnt + CW'(1);
                    if (bit_cnt == CW'(WIDTH - 1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nrzi_serial_tx.sv
// tb/tb_nrzi_serial_tx.sv - self-checking bench for nrzi_serial_tx
module tb_nrzi_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       load_l, load_m;
    logic       ready_l, busy_l, done_l, x_l;
    logic       ready_m, busy_m, done_m, x_m;

    int tests = 0;
    int fails = 0;
    int dcnt_l = 0;
    int dcnt_m = 0;
    logic exp_q[$];

    typedef struct {
        bit         msb;
        logic [7:0] d;
        logic [7:0] exp_x;
    } vec_t;
    vec_t tbl[6];

    nrzi_serial_tx #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_l (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load_l),
        .ready(ready_l), .busy(busy_l), .done(done_l), .x(x_l)
    );

    nrzi_serial_tx #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_m (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load_m),
        .ready(ready_m), .busy(busy_m), .done(done_m), .x(x_m)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_l === 1'b1) dcnt_l++;
        if (done_m === 1'b1) dcnt_m++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // exp_x lists the line level after T+1 in bit 7 down to after T+8 in bit 0.
    task automatic run_word(input bit msb, input logic [7:0] d, input logic [7:0] exp_x,
                            input bit interfere);
        int wc = 0;
        int dc0;
        while ((msb ? ready_m : ready_l) !== 1'b1 && wc < 50) begin
            tick();
            wc++;
        end
        check("ready_before", msb ? ready_m : ready_l, 1);
        dc0 = msb ? dcnt_m : dcnt_l;
        data_in = d;
        if (msb) load_m = 1'b1; else load_l = 1'b1;
        for (int i = 7; i >= 0; i--) exp_q.push_back(exp_x[i]);
        tick();
        load_l = 1'b0;
        load_m = 1'b0;
        data_in = 8'h55;
        check("accept_busy", msb ? busy_m : busy_l, 1);
        check("accept_ready", msb ? ready_m : ready_l, 0);
        for (int k = 1; k <= 8; k++) begin
            if (interfere && k == 3) begin
                data_in = 8'hAA;
                if (msb) load_m = 1'b1; else load_l = 1'b1;
            end
            tick();
            load_l = 1'b0;
            load_m = 1'b0;
            check($sformatf("x_bit%0d", k), msb ? x_m : x_l, exp_q.pop_front());
            check("done_early", msb ? done_m : done_l, 0);
        end
        tick();
        check("done_pulse", msb ? done_m : done_l, 1);
        check("done_ready", msb ? ready_m : ready_l, 1);
        check("done_busy", msb ? busy_m : busy_l, 0);
        tick();
        check("done_clear", msb ? done_m : done_l, 0);
        check("done_count", (msb ? dcnt_m : dcnt_l) - dc0, 1);
    endtask

    initial begin
        tbl[0] = '{1'b0, 8'hB2, 8'b0111_0110};
        tbl[1] = '{1'b0, 8'hFF, 8'b1010_1010};
        tbl[2] = '{1'b0, 8'h00, 8'b0000_0000};
        tbl[3] = '{1'b1, 8'h80, 8'b1111_1111};
        tbl[4] = '{1'b1, 8'hB2, 8'b0010_0011};
        tbl[5] = '{1'b0, 8'h01, 8'b1111_1111};

        rst = 1'b1;
        load_l = 1'b1;
        load_m = 1'b1;
        data_in = 8'hFF;
        tick();
        tick();
        check("rst_x_l", x_l, 0);
        check("rst_ready_l", ready_l, 1);
        check("rst_busy_l", busy_l, 0);
        check("rst_done_l", done_l, 0);
        check("rst_x_m", x_m, 0);
        check("rst_ready_m", ready_m, 1);
        rst = 1'b0;
        load_l = 1'b0;
        load_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_busy", busy_l, 0);
            check("idle_x", x_l, 0);
        end

        foreach (tbl[i]) run_word(tbl[i].msb, tbl[i].d, tbl[i].exp_x, 1'b0);
        run_word(1'b0, 8'hA5, 8'b0011_1001, 1'b0);

        // Reset mid-word discards the word and forces the idle level.
        begin
            int dc0;
            data_in = 8'hFF;
            load_l = 1'b1;
            tick();
            load_l = 1'b0;
            for (int k = 1; k <= 3; k++) tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check("midrst_x", x_l, 0);
            check("midrst_ready", ready_l, 1);
            check("midrst_busy", busy_l, 0);
            check("midrst_done", done_l, 0);
            dc0 = dcnt_l;
            for (int k = 0; k < 12; k++) tick();
            check("midrst_nodone", dcnt_l - dc0, 0);
            check("midrst_x_hold", x_l, 0);
        end

        // Load pulsed mid-word is ignored.
        run_word(1'b0, 8'h0F, 8'b1010_0000, 1'b1);

        // Back-to-back with load held high.
        begin
            logic [7:0] pat;
            pat = 8'b1010_1010;
            data_in = 8'hFF;
            load_l = 1'b1;
            tick();
            data_in = 8'h01;
            for (int k = 1; k <= 8; k++) begin
                tick();
                check($sformatf("b2b_x%0d", k), x_l, pat[8-k]);
            end
            tick();
            check("b2b_done1", done_l, 1);
            check("b2b_x9", x_l, 0);
            check("b2b_ready9", ready_l, 1);
            tick();
            load_l = 1'b0;
            check("b2b_accept2", busy_l, 1);
            check("b2b_x10", x_l, 0);
            check("b2b_done_clr", done_l, 0);
            for (int k = 11; k <= 18; k++) begin
                tick();
                check($sformatf("b2b_x%0d", k), x_l, 1);
            end
            tick();
            check("b2b_done2", done_l, 1);
            check("b2b_x19", x_l, 1);
            check("b2b_ready19", ready_l, 1);
            tick();
            check("b2b_done2_clr", done_l, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
